// File: rtl/reg_write_arbiter_if.sv
// Register-file write port bundle shared by the two writeback sources and the arbiter.
// master = requester side, slave = arbiter side.
interface reg_write_if #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 16
);
   logic              a_req;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_data;
   logic              a_ack;
   logic              b_req;
   logic [ADDR_W-1:0] b_addr;
   logic [DATA_W-1:0] b_data;
   logic              b_ack;
   logic              wr_sel;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [7:0]        conflicts;

   modport master (
      output a_req, a_addr, a_data, b_req, b_addr, b_data,
      input  a_ack, b_ack, wr_sel, wr_en, wr_addr, wr_data, conflicts
   );

   modport slave (
      input  a_req, a_addr, a_data, b_req, b_addr, b_data,
      output a_ack, b_ack, wr_sel, wr_en, wr_addr, wr_data, conflicts
   );
endinterface

// File: rtl/reg_write_arbiter.sv
// Two-source (ALU / load) arbiter for the single register-file write port, registered output.
// Optional R0_GUARD_EN: grants to register 0 are acked but never enable the write.
module reg_write_arbiter #(
   parameter int unsigned ADDR_W  = 4,
   parameter int unsigned DATA_W  = 16,
   parameter bit          RR_MODE = 1'b1
) (
   input logic       clk,
   input logic       rst,
   reg_write_if.slave bus
);

   localparam int unsigned CONF_W   = 8;
   localparam logic [CONF_W-1:0] CONF_MAX = '1;
   localparam logic GRANT_A = 1'b0;
   localparam logic GRANT_B = 1'b1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WRITE_A = 2'd1,
      WRITE_B = 2'd2
   } state_t;

   state_t              state_q,   state_n;
   logic                a_ack_q,   a_ack_n;
   logic                b_ack_q,   b_ack_n;
   logic                wr_en_q,   wr_en_n;
   logic                wr_sel_q,  wr_sel_n;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_n;
   logic [DATA_W-1:0]   wr_data_q, wr_data_n;
   logic [CONF_W-1:0]   conf_q,    conf_n;
   logic                last_q,    last_n;

   logic a_elig, b_elig, tie, pick_b;

   // A source whose write is on the port this cycle cannot be granted again
   assign a_elig = bus.a_req && (state_q != WRITE_A);
   assign b_elig = bus.b_req && (state_q != WRITE_B);
   assign tie    = a_elig && b_elig;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         a_ack_q   <= 1'b0;
         b_ack_q   <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_sel_q  <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         conf_q    <= '0;
         last_q    <= GRANT_B;
      end else begin
         state_q   <= state_n;
         a_ack_q   <= a_ack_n;
         b_ack_q   <= b_ack_n;
         wr_en_q   <= wr_en_n;
         wr_sel_q  <= wr_sel_n;
         wr_addr_q <= wr_addr_n;
         wr_data_q <= wr_data_n;
         conf_q    <= conf_n;
         last_q    <= last_n;
      end
   end

   // Arbitration on this cycle's inputs; winner lands in the output stage next cycle
   always_comb begin
      state_n   = IDLE;
      a_ack_n   = 1'b0;
      b_ack_n   = 1'b0;
      wr_en_n   = 1'b0;
      wr_sel_n  = wr_sel_q;
      wr_addr_n = wr_addr_q;
      wr_data_n = wr_data_q;
      conf_n    = conf_q;
      last_n    = last_q;
      pick_b    = 1'b0;

      if (tie && (conf_q != CONF_MAX)) begin
         conf_n = conf_q + CONF_W'(1);
      end

      if (tie) begin
         pick_b = RR_MODE ? (last_q == GRANT_A) : 1'b0;
      end else begin
         pick_b = b_elig;
      end

      if (a_elig || b_elig) begin
         state_n = pick_b ? WRITE_B : WRITE_A;
      end

      unique case (state_n)
         WRITE_A: begin
            a_ack_n   = 1'b1;
            wr_sel_n  = 1'b0;
            wr_addr_n = bus.a_addr;
            wr_data_n = bus.a_data;
            last_n    = GRANT_A;
         end
         WRITE_B: begin
            b_ack_n   = 1'b1;
            wr_sel_n  = 1'b1;
            wr_addr_n = bus.b_addr;
            wr_data_n = bus.b_data;
            last_n    = GRANT_B;
         end
         default: ;
      endcase

      if (state_n != IDLE) begin
`ifdef R0_GUARD_EN
         wr_en_n = (wr_addr_n != '0);
`else
         wr_en_n = 1'b1;
`endif
      end
   end

   assign bus.a_ack     = a_ack_q;
   assign bus.b_ack     = b_ack_q;
   assign bus.wr_en     = wr_en_q;
   assign bus.wr_sel    = wr_sel_q;
   assign bus.wr_addr   = wr_addr_q;
   assign bus.wr_data   = wr_data_q;
   assign bus.conflicts = conf_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: one round-robin and one fixed-priority instance.
module tb_reg_write_arbiter;

   localparam int unsigned ADDR_W = 4;
   localparam int unsigned DATA_W = 16;
`ifdef R0_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   reg_write_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) rr_if ();
   reg_write_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) fx_if ();

   reg_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RR_MODE(1'b1)) u_rr (
      .clk(clk), .rst(rst), .bus(rr_if.slave));
   reg_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RR_MODE(1'b0)) u_fx (
      .clk(clk), .rst(rst), .bus(fx_if.slave));

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        a_req;
      logic [3:0]  a_addr;
      logic [15:0] a_data;
      logic        b_req;
      logic [3:0]  b_addr;
      logic [15:0] b_data;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [16];

   // {a_ack, b_ack, wr_en, wr_sel, wr_addr, wr_data, conflicts}
   function automatic logic [31:0] mk(input bit aa, input bit ba, input bit en, input bit sel,
                                      input logic [3:0] addr, input logic [15:0] data,
                                      input logic [7:0] conf);
      return {aa, ba, en, sel, addr, data, conf};
   endfunction

   function automatic logic [31:0] get_rr();
      return {rr_if.a_ack, rr_if.b_ack, rr_if.wr_en, rr_if.wr_sel,
              rr_if.wr_addr, rr_if.wr_data, rr_if.conflicts};
   endfunction

   function automatic logic [31:0] get_fx();
      return {fx_if.a_ack, fx_if.b_ack, fx_if.wr_en, fx_if.wr_sel,
              fx_if.wr_addr, fx_if.wr_data, fx_if.conflicts};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (a_ack,b_ack,en,sel|addr|data|conf)",
                  name, act, exp);
      end
   endtask

   task automatic drive_rr(input bit ar, input logic [3:0] aa, input logic [15:0] ad,
                           input bit br, input logic [3:0] ba, input logic [15:0] bd);
      rr_if.a_req = ar; rr_if.a_addr = aa; rr_if.a_data = ad;
      rr_if.b_req = br; rr_if.b_addr = ba; rr_if.b_data = bd;
   endtask

   task automatic drive_fx(input bit ar, input logic [3:0] aa, input logic [15:0] ad,
                           input bit br, input logic [3:0] ba, input logic [15:0] bd);
      fx_if.a_req = ar; fx_if.a_addr = aa; fx_if.a_data = ad;
      fx_if.b_req = br; fx_if.b_addr = ba; fx_if.b_data = bd;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Round-robin instance; last_grant=B on entry (set by the B grant in row 3)
      vecs[0]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, mk(1'b0,1'b0,1'b0,1'b0,4'd9,16'h00AA,8'd0)};
      vecs[1]  = '{1'b1, 4'd5, 16'h1234, 1'b0, 4'd0, 16'h0000, mk(1'b1,1'b0,1'b1,1'b0,4'd5,16'h1234,8'd0)};
      vecs[2]  = '{1'b0, 4'd5, 16'h1234, 1'b0, 4'd0, 16'h0000, mk(1'b0,1'b0,1'b0,1'b0,4'd5,16'h1234,8'd0)};
      vecs[3]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd2, 16'h2222, mk(1'b0,1'b1,1'b1,1'b1,4'd2,16'h2222,8'd0)};
      vecs[4]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd2, 16'h2222, mk(1'b0,1'b0,1'b0,1'b1,4'd2,16'h2222,8'd0)};
      vecs[5]  = '{1'b1, 4'd3, 16'h0333, 1'b1, 4'd7, 16'h0777, mk(1'b1,1'b0,1'b1,1'b0,4'd3,16'h0333,8'd1)};
      vecs[6]  = '{1'b1, 4'd3, 16'h0333, 1'b1, 4'd7, 16'h0777, mk(1'b0,1'b1,1'b1,1'b1,4'd7,16'h0777,8'd1)};
      vecs[7]  = '{1'b1, 4'd3, 16'h0333, 1'b1, 4'd7, 16'h0777, mk(1'b1,1'b0,1'b1,1'b0,4'd3,16'h0333,8'd1)};
      vecs[8]  = '{1'b0, 4'd3, 16'h0333, 1'b0, 4'd7, 16'h0777, mk(1'b0,1'b0,1'b0,1'b0,4'd3,16'h0333,8'd1)};
      vecs[9]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd0, 16'hFFFF, mk(1'b0,1'b1,~GUARD,1'b1,4'd0,16'hFFFF,8'd1)};
      vecs[10] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'hFFFF, mk(1'b0,1'b0,1'b0,1'b1,4'd0,16'hFFFF,8'd1)};
      vecs[11] = '{1'b1, 4'd1, 16'h0101, 1'b0, 4'd0, 16'h0000, mk(1'b1,1'b0,1'b1,1'b0,4'd1,16'h0101,8'd1)};
      vecs[12] = '{1'b0, 4'd1, 16'h0101, 1'b0, 4'd0, 16'h0000, mk(1'b0,1'b0,1'b0,1'b0,4'd1,16'h0101,8'd1)};
      vecs[13] = '{1'b1, 4'd4, 16'h0444, 1'b1, 4'd8, 16'h0888, mk(1'b0,1'b1,1'b1,1'b1,4'd8,16'h0888,8'd2)};
      vecs[14] = '{1'b1, 4'd4, 16'h0444, 1'b1, 4'd8, 16'h0888, mk(1'b1,1'b0,1'b1,1'b0,4'd4,16'h0444,8'd2)};
      vecs[15] = '{1'b0, 4'd4, 16'h0444, 1'b0, 4'd8, 16'h0888, mk(1'b0,1'b0,1'b0,1'b0,4'd4,16'h0444,8'd2)};

      drive_rr(1'b1, 4'd9, 16'h00AA, 1'b0, 4'd0, 16'h0000);
      drive_fx(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000);
      #1 rst = 1'b1;
      #1;
      check("rr_reset", get_rr(), mk(1'b0,1'b0,1'b0,1'b0,4'd0,16'h0000,8'd0));
      check("fx_reset", get_fx(), mk(1'b0,1'b0,1'b0,1'b0,4'd0,16'h0000,8'd0));

      #10 rst = 1'b0;
      step();
      check("rr_first_after_release", get_rr(), mk(1'b1,1'b0,1'b1,1'b0,4'd9,16'h00AA,8'd0));

      // Mid-cycle reset while A is being acked and still requesting
      #2 rst = 1'b1;
      #1;
      check("rr_async_reset", get_rr(), mk(1'b0,1'b0,1'b0,1'b0,4'd0,16'h0000,8'd0));
      step();
      #2 rst = 1'b0;
      step();
      check("rr_rearb_after_reset", get_rr(), mk(1'b1,1'b0,1'b1,1'b0,4'd9,16'h00AA,8'd0));

      for (int i = 0; i < 16; i++) begin
         drive_rr(vecs[i].a_req, vecs[i].a_addr, vecs[i].a_data,
                  vecs[i].b_req, vecs[i].b_addr, vecs[i].b_data);
         step();
         check($sformatf("rr_row%0d", i), get_rr(), vecs[i].exp);
      end

      // Fixed priority: held requests alternate because the acked source is ineligible
      drive_fx(1'b1, 4'd3, 16'h0333, 1'b1, 4'd7, 16'h0777);
      step(); check("fx_hold1_a", get_fx(), mk(1'b1,1'b0,1'b1,1'b0,4'd3,16'h0333,8'd1));
      step(); check("fx_hold2_b", get_fx(), mk(1'b0,1'b1,1'b1,1'b1,4'd7,16'h0777,8'd1));
      step(); check("fx_hold3_a", get_fx(), mk(1'b1,1'b0,1'b1,1'b0,4'd3,16'h0333,8'd1));
      step(); check("fx_hold4_b", get_fx(), mk(1'b0,1'b1,1'b1,1'b1,4'd7,16'h0777,8'd1));
      drive_fx(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000);
      step(); check("fx_idle1", get_fx(), mk(1'b0,1'b0,1'b0,1'b1,4'd7,16'h0777,8'd1));
      drive_fx(1'b1, 4'd2, 16'h0202, 1'b0, 4'd0, 16'h0000);
      step(); check("fx_a_alone", get_fx(), mk(1'b1,1'b0,1'b1,1'b0,4'd2,16'h0202,8'd1));
      drive_fx(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000);
      step(); check("fx_idle2", get_fx(), mk(1'b0,1'b0,1'b0,1'b0,4'd2,16'h0202,8'd1));
      // Tie right after an A grant: fixed priority still picks A
      drive_fx(1'b1, 4'd5, 16'h0555, 1'b1, 4'd6, 16'h0666);
      step(); check("fx_tie_after_a", get_fx(), mk(1'b1,1'b0,1'b1,1'b0,4'd5,16'h0555,8'd2));
      drive_fx(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000);
      step(); check("fx_idle3", get_fx(), mk(1'b0,1'b0,1'b0,1'b0,4'd5,16'h0555,8'd2));

      // 300 tie cycles, separated by idle cycles so both stay eligible
      for (int i = 0; i < 300; i++) begin
         drive_rr(1'b1, 4'd1, 16'h0011, 1'b1, 4'd2, 16'h0022);
         step();
         drive_rr(1'b0, 4'd1, 16'h0011, 1'b0, 4'd2, 16'h0022);
         step();
      end
      check("rr_conflicts_saturate", 32'(rr_if.conflicts), 32'd255);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
